// File: rtl/pattern_sequencer_if.sv
// Bundle between the game controller (master) and the pattern sequencer
// (slave): generator control inputs plus the lookahead queue view.
interface pattern_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) ();

    logic [1:0]                     mode;
    logic [WIDTH-1:0]               stride;
    logic                           load;
    logic [WIDTH-1:0]               load_value;
    logic                           adv;
    logic [WIDTH-1:0]               head;
    logic                           valid;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic [DEPTH*WIDTH-1:0]         lookahead;

    modport master (
        output mode, stride, load, load_value, adv,
        input  head, valid, count, lookahead
    );

    modport slave (
        input  mode, stride, load, load_value, adv,
        output head, valid, count, lookahead
    );

endinterface

// File: rtl/pattern_sequencer.sv
// Note-pattern generator feeding a DEPTH-entry lookahead queue. The generator
// register holds the next pattern to enqueue; the queue refills one entry per
// cycle and the head is consumed on each beat strobe.
module pattern_sequencer #(
    parameter int               WIDTH = 4,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic               clk,
    input  logic               rst,
    pattern_sequencer_if.slave bus
);

    localparam int                CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] gen_q, gen_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] slots_q [DEPTH];
    logic [WIDTH-1:0] slots_d [DEPTH];
    logic [WIDTH-1:0] gen_next;

    // Successor of the generator value for the currently selected mode.
    always_comb begin
        gen_next = gen_q;
        case (bus.mode)
            2'b00:   gen_next = gen_q + bus.stride;
            2'b01:   gen_next = (gen_q == '0) ? WIDTH'(1)
                                : {gen_q[WIDTH-2:0], ^(gen_q & TAPS)};
            2'b10:   gen_next = {gen_q[WIDTH-2:0], gen_q[WIDTH-1]};
            default: gen_next = gen_q;
        endcase
    end

    // Queue update: load flushes and reseeds; otherwise pop shifts toward the
    // head and push writes gen into the first free slot after any pop.
    always_comb begin
        logic          do_pop;
        logic          do_push;
        logic [CW-1:0] base;
        gen_d   = gen_q;
        count_d = count_q;
        slots_d = slots_q;
        do_pop  = 1'b0;
        do_push = 1'b0;
        base    = count_q;
        if (bus.load) begin
            slots_d = '{default: '0};
            count_d = '0;
            gen_d   = bus.load_value;
        end else begin
            do_pop  = bus.adv && (count_q != '0);
            do_push = (count_q < DEPTH_C) || ((count_q == DEPTH_C) && bus.adv);
            if (do_pop) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    slots_d[k] = slots_q[k+1];
                end
                slots_d[DEPTH-1] = '0;
                base = count_q - CW'(1);
            end
            if (do_push) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (CW'(k) == base) begin
                        slots_d[k] = gen_q;
                    end
                end
                gen_d = gen_next;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers with synchronous reset to an empty queue and SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_q   <= SEED;
            count_q <= '0;
            slots_q <= '{default: '0};
        end else begin
            gen_q   <= gen_d;
            count_q <= count_d;
            slots_q <= slots_d;
        end
    end

    assign bus.head  = slots_q[0];
    assign bus.valid = (count_q != '0);
    assign bus.count = count_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_look
        assign bus.lookahead[k*WIDTH +: WIDTH] = slots_q[k];
    end

endmodule
